mem_copy_dma: RTL and testbench

Single-channel memory copy/fill engine that acts as a second initiator on the single-port block-RAM interface used by `VerySimpleCPU`. It drives `wrEn`, `addr_toRAM` and `data_toRAM`, and consumes `data_fromRAM`. The RAM has a one-cycle registered read latency. The engine copies or fills a block of 32-bit words under a start/busy/done handshake, so a loader or host can stage program and data images without involving the CPU. Arbitration against the CPU is external: while `busy` is high, this block owns the RAM port.

---
 rtl/mem_copy_dma.sv | 141 ++++++++++++++
 tb/tb_mem_copy_dma.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Single-channel block-RAM copy/fill engine that shares the CPU's RAM port while busy.
// Copy alternates read/write cycles against the one-cycle read latency; fill writes every cycle.
module mem_copy_dma #(
    parameter int SIZE  = 14,
    parameter int LEN_W = SIZE + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [SIZE-1:0]  i_src_addr,
    input  logic [SIZE-1:0]  i_dst_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic [31:0]      i_fill_value,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_words_done,
    output logic             o_wrEn,
    output logic [SIZE-1:0]  o_addr_toRAM,
    output logic [31:0]      o_data_toRAM,
    input  logic [31:0]      i_data_fromRAM
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SIZE-1:0]  r_src_ptr;
    logic [SIZE-1:0]  r_dst_ptr;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_words_done;
    logic [31:0]      r_fill_value;
    logic             w_last;

    assign w_last       = (r_remaining == LEN_W'(1'b1));
    assign o_words_done = r_words_done;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer parameters and progress; the mode is carried by the RD/FILL branch taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src_ptr    <= {SIZE{1'b0}};
            r_dst_ptr    <= {SIZE{1'b0}};
            r_remaining  <= {LEN_W{1'b0}};
            r_words_done <= {LEN_W{1'b0}};
            r_fill_value <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src_ptr    <= i_src_addr;
                        r_dst_ptr    <= i_dst_addr;
                        r_remaining  <= i_len;
                        r_words_done <= {LEN_W{1'b0}};
                        r_fill_value <= i_fill_value;
                    end
                end
                S_RD: begin
                    r_src_ptr <= r_src_ptr + SIZE'(1'b1);
                end
                S_WR, S_FILL: begin
                    r_dst_ptr    <= r_dst_ptr + SIZE'(1'b1);
                    r_remaining  <= r_remaining - LEN_W'(1'b1);
                    r_words_done <= r_words_done + LEN_W'(1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_start) begin
                    w_state_nxt = S_IDLE;
                end else if (i_len == {LEN_W{1'b0}}) begin
                    w_state_nxt = S_FIN;
                end else if (i_mode) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD:    w_state_nxt = S_WR;
            S_WR:    w_state_nxt = w_last ? S_FIN : S_RD;
            S_FILL:  w_state_nxt = w_last ? S_FIN : S_FILL;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM port and status decode; read data passes straight through only in WR
    always_comb begin
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_wrEn       = 1'b0;
        o_addr_toRAM = {SIZE{1'b0}};
        o_data_toRAM = 32'h0000_0000;
        case (r_state)
            S_RD: begin
                o_busy       = 1'b1;
                o_addr_toRAM = r_src_ptr;
            end
            S_WR: begin
                o_busy       = 1'b1;
                o_wrEn       = 1'b1;
                o_addr_toRAM = r_dst_ptr;
                o_data_toRAM = i_data_fromRAM;
            end
            S_FILL: begin
                o_busy       = 1'b1;
                o_wrEn       = 1'b1;
                o_addr_toRAM = r_dst_ptr;
                o_data_toRAM = r_fill_value;
            end
            S_FIN: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural one-cycle-latency RAM.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [13:0] src;
    logic [13:0] dst;
    logic [14:0] len;
    logic [31:0] fillv;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [14:0] wd;
    logic [13:0] addr;
    logic [31:0] dout;
    logic [31:0] din;

    logic [31:0] mem [0:16383];
    logic        bd_we;
    logic [13:0] bd_addr;
    logic [31:0] bd_data;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;
    int wr_cnt;
    int done_at;

    always #5 clk = ~clk;

    mem_copy_dma #(.SIZE(14), .LEN_W(15)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_mode         (mode),
        .i_src_addr     (src),
        .i_dst_addr     (dst),
        .i_len          (len),
        .i_fill_value   (fillv),
        .o_busy         (busy),
        .o_done         (done),
        .o_words_done   (wd),
        .o_wrEn         (wr_en),
        .o_addr_toRAM   (addr),
        .o_data_toRAM   (dout),
        .i_data_fromRAM (din)
    );

    // RAM model with a backdoor preload port
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (wr_en) mem[addr] <= dout;
        din <= mem[addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [13:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    // Pulse start, then watch until done; optionally pulse a stray start at cycle 'inject'
    task automatic xfer(input logic m, input logic [13:0] s, input logic [13:0] d,
                        input logic [14:0] l, input logic [31:0] f, input int inject);
        mode = m; src = s; dst = d; len = l; fillv = f; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0; wr_cnt = 0; done_at = -1;
        for (int c = 0; c < 100; c++) begin
            if (c == inject) begin
                start = 1'b1; mode = 1'b1; src = 14'd3; dst = 14'd950;
                len = 15'd2; fillv = 32'hBAD0_BAD0;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (wr_en) wr_cnt++;
            if (done) begin
                done_at = c;
                break;
            end
            tick();
        end
        start = 1'b0;
        chk("done_seen", 32'(done_at != -1), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = 14'd0; dst = 14'd0;
        len = 15'd0; fillv = 32'h0; bd_we = 1'b0; bd_addr = 14'd0; bd_data = 32'h0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick();

        poke(14'd500, 32'h33); poke(14'd501, 32'h6); poke(14'd502, 32'hA);
        poke(14'd519, 32'h1111_1111); poke(14'd524, 32'h2222_2222);
        poke(14'd700, 32'h5A5A); poke(14'd1, 32'h99); poke(14'd950, 32'hAB);
        for (int i = 0; i < 5; i++) poke(14'(800 + i), 32'(16 + i));
        for (int i = 0; i < 4; i++) begin
            poke(14'(1000 + i), 32'(32 + i));
            poke(14'(1100 + i), 32'hFFFF_0000 + 32'(i));
        end

        // Copy 3 words
        xfer(1'b0, 14'd500, 14'd600, 15'd3, 32'h0, -1);
        chk("cp_done_at", 32'(done_at), 32'd6);
        chk("cp_busy", 32'(busy_cnt), 32'd6);
        chk("cp_wr", 32'(wr_cnt), 32'd3);
        chk("cp_wd", 32'(wd), 32'd3);
        chk("cp_m600", mem[600], 32'h33);
        chk("cp_m601", mem[601], 32'h6);
        chk("cp_m602", mem[602], 32'hA);

        // Fill 4 words
        xfer(1'b1, 14'd520, 14'd520, 15'd4, 32'hDEAD_BEEF, -1);
        chk("fl_done_at", 32'(done_at), 32'd4);
        chk("fl_busy", 32'(busy_cnt), 32'd4);
        chk("fl_wd", 32'(wd), 32'd4);
        for (int i = 520; i < 524; i++) chk("fl_mem", mem[i], 32'hDEAD_BEEF);
        chk("fl_m519", mem[519], 32'h1111_1111);
        chk("fl_m524", mem[524], 32'h2222_2222);

        // Zero length
        xfer(1'b1, 14'd700, 14'd700, 15'd0, 32'h1234_5678, -1);
        chk("z_done_at", 32'(done_at), 32'd0);
        chk("z_busy", 32'(busy_cnt), 32'd0);
        chk("z_wr", 32'(wr_cnt), 32'd0);
        chk("z_wd", 32'(wd), 32'd0);
        chk("z_m700", mem[700], 32'h5A5A);

        // Fill across the top of memory
        xfer(1'b1, 14'd0, 14'd16382, 15'd3, 32'h7, -1);
        chk("wr_m16382", mem[16382], 32'h7);
        chk("wr_m16383", mem[16383], 32'h7);
        chk("wr_m0", mem[0], 32'h7);
        chk("wr_m1", mem[1], 32'h99);
        chk("wr_wd", 32'(wd), 32'd3);

        // Stray start during a 5-word copy
        xfer(1'b0, 14'd800, 14'd900, 15'd5, 32'h0, 3);
        chk("ig_done_at", 32'(done_at), 32'd10);
        chk("ig_busy", 32'(busy_cnt), 32'd10);
        chk("ig_wd", 32'(wd), 32'd5);
        for (int i = 0; i < 5; i++) chk("ig_mem", mem[900 + i], 32'(16 + i));
        chk("ig_m950", mem[950], 32'hAB);

        // Reset during the second write of a 4-word copy
        mode = 1'b0; src = 14'd1000; dst = 14'd1100; len = 15'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ab_pre_wren", 32'(wr_en), 32'd1);
        chk("ab_pre_addr", 32'(addr), 32'd1101);
        rst_n = 1'b0;
        #1;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_wren", 32'(wr_en), 32'd0);
        chk("ab_addr", 32'(addr), 32'd0);
        chk("ab_data", dout, 32'd0);
        chk("ab_wd", 32'(wd), 32'd0);
        tick();
        chk("ab_no_done", 32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("ab_m1100", mem[1100], 32'h20);
        chk("ab_m1101", mem[1101], 32'hFFFF_0001);
        chk("ab_m1102", mem[1102], 32'hFFFF_0002);

        // Normal transfer after the abort
        xfer(1'b0, 14'd1000, 14'd1200, 15'd2, 32'h0, -1);
        chk("po_done_at", 32'(done_at), 32'd4);
        chk("po_wd", 32'(wd), 32'd2);
        chk("po_m1200", mem[1200], 32'h20);
        chk("po_m1201", mem[1201], 32'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
